// File: rtl/dmem_if_pkg.sv
// Shared encodings for the data-memory access controller: size codes,
// FSM state encoding and byte-lane index widths.
package dmem_if_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam int LANE_W = 2;
    localparam int HALF_W = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: merges sub-word store data into a read
// word, and extracts/extends sub-word load data from a memory word.
module mem_lane_align
    import dmem_if_pkg::*;
(
    input  logic [31:0]       st_word,
    input  logic [15:0]       wdata,
    input  logic [31:0]       ld_word,
    input  logic [1:0]        size,
    input  logic [LANE_W-1:0] lane,
    input  logic              is_unsigned,
    output logic [31:0]       merged,
    output logic [31:0]       ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        merged = st_word;
        case (size)
            SZ_B:    merged[{lane, 3'b000} +: 8] = wdata[7:0];
            SZ_H:    merged[{lane[1], 4'b0000} +: 16] = wdata;
            default: merged = st_word;
        endcase
    end

    always_comb begin
        ld_byte = ld_word[{lane, 3'b000} +: 8];
        ld_half = ld_word[{lane[1], 4'b0000} +: 16];
        case (size)
            SZ_B:    ld_data = {{24{~is_unsigned & ld_byte[7]}}, ld_byte};
            SZ_H:    ld_data = {{16{~is_unsigned & ld_half[15]}}, ld_half};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Initiator-side data-memory controller: load/store requests in, word-aligned
// memory port out, read-modify-write for sub-word stores, one-cycle response.
module dmem_access_ctrl
    import dmem_if_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter bit STRICT_ALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [31:0]       mem_d_in,
    output logic              mem_mrd,
    output logic              mem_mwr,
    input  logic [31:0]       mem_d_out
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [1:0]        size;
    logic              we;
    logic              uns;
    logic [31:0]       cap_word;

    logic              accept;
    logic [1:0]        size_in;
    logic              misaligned;
    logic [ADDR_W-1:0] addr_in;
    logic [31:0]       merged;
    logic [31:0]       ld_data;

    assign accept  = req_valid && req_ready;
    assign size_in = (req_size == 2'b11) ? SZ_W : req_size;
    assign misaligned = ((size_in == SZ_H) && req_addr[0]) ||
                        ((size_in == SZ_W) && (req_addr[1:0] != 2'b00));

    // With relaxed alignment the offending low bits are dropped at latch time,
    // so the lane logic downstream always sees a size-aligned address.
    always_comb begin
        addr_in = req_addr;
        if (!STRICT_ALIGN) begin
            if (size_in == SZ_H) addr_in[0] = 1'b0;
            if (size_in == SZ_W) addr_in[1:0] = 2'b00;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (misaligned && STRICT_ALIGN)       state_nxt = RESP;
                    else if (!req_we || size_in != SZ_W) state_nxt = RD;
                    else                                 state_nxt = WR;
                end
            end
            RD:      state_nxt = we ? WR : RESP;
            WR:      state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            wdata     <= '0;
            size      <= '0;
            we        <= 1'b0;
            uns       <= 1'b0;
            cap_word  <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr  <= addr_in;
                        wdata <= req_wdata;
                        size  <= size_in;
                        we    <= req_we;
                        uns   <= req_unsigned;
                        if (misaligned && STRICT_ALIGN) begin
                            rsp_rdata <= '0;
                            rsp_err   <= 1'b1;
                        end
                    end
                end
                RD: begin
                    cap_word <= mem_d_out;
                    if (!we) begin
                        rsp_rdata <= ld_data;
                        rsp_err   <= 1'b0;
                    end
                end
                WR: begin
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    mem_lane_align u_align (
        .st_word     (cap_word),
        .wdata       (wdata[15:0]),
        .ld_word     (mem_d_out),
        .size        (size),
        .lane        (addr[LANE_W-1:0]),
        .is_unsigned (uns),
        .merged      (merged),
        .ld_data     (ld_data)
    );

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign mem_mrd   = (state == RD);
    assign mem_mwr   = (state == WR);
    assign mem_adr   = (mem_mrd || mem_mwr) ? {addr[ADDR_W-1:2], 2'b00} : '0;
    assign mem_d_in  = mem_mwr ? ((size == SZ_W) ? wdata : merged) : 32'h0;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a small byte-addressed memory model.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_adr;
    logic [31:0] mem_d_in;
    logic        mem_mrd;
    logic        mem_mwr;
    logic [31:0] mem_d_out;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem [0:63];
    logic        pre_we = 1'b0;
    logic [5:0]  pre_idx = 6'd0;
    logic [31:0] pre_data = 32'h0;

    int          r_lat, r_mrd_cnt, r_mwr_cnt, r_mrd_first, r_mwr_first;
    logic [31:0] r_rdata, r_adr, r_din;
    logic        r_err;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.ADDR_W(32), .STRICT_ALIGN(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_adr      (mem_adr),
        .mem_d_in     (mem_d_in),
        .mem_mrd      (mem_mrd),
        .mem_mwr      (mem_mwr),
        .mem_d_out    (mem_d_out)
    );

    assign mem_d_out = mem_mrd ? mem[mem_adr[7:2]] : 32'h0;

    always @(posedge clk) begin
        if (pre_we)       mem[pre_idx] <= pre_data;
        else if (mem_mwr) mem[mem_adr[7:2]] <= mem_d_in;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = idx; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Issues one request and records per-cycle memory activity, counting
    // cycles from the accept edge (cycle 1 is the one right after it).
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd);
        r_lat = 0; r_mrd_cnt = 0; r_mwr_cnt = 0; r_mrd_first = 0; r_mwr_first = 0;
        r_rdata = 32'hx; r_err = 1'bx; r_adr = 32'hx; r_din = 32'hx;
        @(negedge clk);
        chk("ready_before_req", {31'b0, req_ready}, 32'd1);
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 1) req_valid = 1'b0;
            if (mem_mrd) begin
                r_mrd_cnt++;
                if (r_mrd_first == 0) r_mrd_first = n;
                r_adr = mem_adr;
            end
            if (mem_mwr) begin
                r_mwr_cnt++;
                if (r_mwr_first == 0) r_mwr_first = n;
                r_adr = mem_adr;
                r_din = mem_d_in;
            end
            if (rsp_valid) begin
                r_lat = n; r_rdata = rsp_rdata; r_err = rsp_err;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          rsp_cnt, mwr_cnt;
        logic [6:0]  rsp_mask;
        logic [31:0] d0, d1;
        logic        rdy3;

        req_valid = 1'b1;
        req_addr  = 32'd104;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_err", {31'b0, rsp_err}, 32'd0);
        chk("rst_enables", {30'b0, mem_mrd, mem_mwr}, 32'd0);
        chk("rst_adr", mem_adr, 32'h0);
        chk("rst_d_in", mem_d_in, 32'h0);
        req_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", {30'b0, req_ready, rsp_valid}, 32'd2);

        preload(6'd26, 32'h8000_0001);
        do_req(1'b0, 2'b10, 1'b0, 32'd104, 32'h0);
        chk("lw_lat", r_lat, 2);
        chk("lw_rdata", r_rdata, 32'h8000_0001);
        chk("lw_err", {31'b0, r_err}, 32'd0);
        chk("lw_mrd_first", r_mrd_first, 1);
        chk("lw_mrd_cnt", r_mrd_cnt, 1);
        chk("lw_adr", r_adr, 32'd104);
        chk("lw_mwr_cnt", r_mwr_cnt, 0);
        @(negedge clk);
        chk("lw_hold_rdata", rsp_rdata, 32'h8000_0001);
        chk("lw_rsp_one_cycle", {31'b0, rsp_valid}, 32'd0);

        do_req(1'b0, 2'b01, 1'b0, 32'd106, 32'h0);
        chk("lh_rdata", r_rdata, 32'hFFFF_8000);
        do_req(1'b0, 2'b01, 1'b1, 32'd104, 32'h0);
        chk("lhu_rdata", r_rdata, 32'h0000_0001);

        preload(6'd26, 32'h0000_80FF);
        do_req(1'b0, 2'b00, 1'b0, 32'd105, 32'h0);
        chk("lb_rdata", r_rdata, 32'hFFFF_FF80);
        chk("lb_lat", r_lat, 2);
        do_req(1'b0, 2'b00, 1'b1, 32'd105, 32'h0);
        chk("lbu_rdata", r_rdata, 32'h0000_0080);

        preload(6'd50, 32'h1122_3344);
        do_req(1'b1, 2'b00, 1'b0, 32'd202, 32'h0000_00AB);
        chk("sb_mrd_first", r_mrd_first, 1);
        chk("sb_mwr_first", r_mwr_first, 2);
        chk("sb_mwr_cnt", r_mwr_cnt, 1);
        chk("sb_d_in", r_din, 32'h11AB_3344);
        chk("sb_adr", r_adr, 32'd200);
        chk("sb_lat", r_lat, 3);
        chk("sb_rdata", r_rdata, 32'h0);
        chk("sb_mem", mem[50], 32'h11AB_3344);
        do_req(1'b0, 2'b10, 1'b0, 32'd200, 32'h0);
        chk("lw_after_sb", r_rdata, 32'h11AB_3344);

        do_req(1'b1, 2'b01, 1'b0, 32'd201, 32'h0000_5566);
        chk("sh_mis_lat", r_lat, 1);
        chk("sh_mis_err", {31'b0, r_err}, 32'd1);
        chk("sh_mis_rdata", r_rdata, 32'h0);
        chk("sh_mis_access", r_mrd_cnt + r_mwr_cnt, 0);
        chk("sh_mis_mem", mem[50], 32'h11AB_3344);
        @(negedge clk);
        chk("err_hold", {31'b0, rsp_err}, 32'd1);

        preload(6'd52, 32'h0);
        do_req(1'b1, 2'b11, 1'b0, 32'd208, 32'hDEAD_BEEF);
        chk("sw_lat", r_lat, 2);
        chk("sw_mwr_first", r_mwr_first, 1);
        chk("sw_mrd_cnt", r_mrd_cnt, 0);
        chk("sw_d_in", r_din, 32'hDEAD_BEEF);
        chk("sw_err_clear", {31'b0, r_err}, 32'd0);
        chk("sw_mem", mem[52], 32'hDEAD_BEEF);

        // Reset asserted while a byte store is in its read phase.
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'd200; req_wdata = 32'h0000_0077; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rrd_mrd_before", {31'b0, mem_mrd}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rrd_mrd_async_drop", {31'b0, mem_mrd}, 32'd0);
        chk("rrd_adr_reset", mem_adr, 32'h0);
        rsp_cnt = 0; mwr_cnt = 0;
        @(negedge clk);
        if (mem_mwr) mwr_cnt++;
        if (rsp_valid) rsp_cnt++;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (mem_mwr) mwr_cnt++;
            if (rsp_valid) rsp_cnt++;
        end
        chk("rrd_no_write", mwr_cnt, 0);
        chk("rrd_no_rsp", rsp_cnt, 0);
        chk("rrd_mem", mem[50], 32'h11AB_3344);
        chk("rrd_ready", {31'b0, req_ready}, 32'd1);

        // Back-to-back loads with req_valid held high.
        preload(6'd26, 32'h8000_0001);
        preload(6'd27, 32'h0BAD_F00D);
        @(negedge clk);
        req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'd104; req_valid = 1'b1;
        rsp_mask = 7'b0; rsp_cnt = 0; d0 = 32'hx; d1 = 32'hx; rdy3 = 1'b0;
        @(posedge clk);
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            if (n == 1) req_addr = 32'd108;
            if (n == 3) rdy3 = req_ready;
            if (rsp_valid) begin
                rsp_mask[n-1] = 1'b1;
                if (rsp_cnt == 0) d0 = rsp_rdata;
                else              d1 = rsp_rdata;
                rsp_cnt++;
            end
            if (n == 4) req_valid = 1'b0;
        end
        chk("b2b_ready_after_resp", {31'b0, rdy3}, 32'd1);
        chk("b2b_rsp_cycles", {25'b0, rsp_mask}, 32'h0000_0012);
        chk("b2b_rsp_cnt", rsp_cnt, 2);
        chk("b2b_data0", d0, 32'h8000_0001);
        chk("b2b_data1", d1, 32'h0BAD_F00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
